fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  async active-low reset.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  16  byte address of the request; stable while imem_req high.
REQ-006 imem_ack  in  1  read data valid, 1-cycle pulse.
REQ-007 imem_rdata  in  16  instruction word; valid with imem_ack.
REQ-008 if_valid  out  1  instruction available to decode.
REQ-009 if_instr  out  16  fetched instruction; opcode in [15:12].
REQ-010 if_pc  out  16  address of if_instr.
REQ-011 if_pc_plus2  out  16  if_pc+2, for the PCS writeback.
REQ-012 id_ready  in  1  decode accepts if_instr this cycle.
REQ-013 halt  in  1  decoder Halt for the instruction currently on if_instr.
REQ-014 redirect  in  1  branch taken; load redirect_pc.
REQ-015 redirect_pc  in  16  branch target.
REQ-016 halted  out  1  fetch stopped permanently until reset.
REQ-017 fetch_err  out  1  memory timeout flag.

Function
REQ-018 The block SHALL implement states FETCH, HOLD and HALTED.
REQ-019 FETCH: imem_req=1 and imem_addr=pc until imem_ack; on ack: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+2, go to HOLD.
REQ-020 Latency: imem_ack in cycle N SHALL give if_valid=1 in cycle N+1; imem_req=0 in HOLD.
REQ-021 HOLD: if_valid and if_instr SHALL be held stable until id_ready=1.
REQ-022 HOLD with id_ready=1 and halt=0: if_valid<=0, go to FETCH, and a new request is issued in the next cycle.
REQ-023 HOLD with id_ready=1 and halt=1: if_valid<=0, halted<=1, go to HALTED.
REQ-024 halt SHALL be ignored unless if_valid=1 and id_ready=1.
REQ-025 redirect=1 in FETCH or HOLD: pc<=redirect_pc with bit0 forced to 0, if_valid<=0, go to FETCH; an imem_ack in the same cycle SHALL be discarded.
REQ-026 redirect SHALL take priority over halt and imem_ack in the same cycle.
REQ-027 PC arithmetic is 16-bit modulo: 0xFFFE+2 = 0x0000, with no flag.
REQ-028 HALTED: imem_req=0, if_valid=0, halted=1; redirect, imem_ack and id_ready are ignored; exit only by reset.
REQ-029 imem_ack while imem_req=0 SHALL be ignored.
REQ-030 if_pc_plus2 SHALL always equal if_pc+2 modulo 2^16.

Reset
REQ-031 rst_n low SHALL immediately force state=FETCH, pc=0x0000, imem_req=0, if_valid=0, if_instr=0x0000, if_pc=0x0000, halted=0, fetch_err=0, and clear the timeout counter.
REQ-032 The first request (imem_addr=0x0000) SHALL be issued in the first cycle after rst_n rises; an outstanding transaction is abandoned.

Configuration
REQ-033 With FETCH_TIMEOUT_EN defined, a 4-bit counter SHALL count FETCH cycles without imem_ack.
REQ-034 With FETCH_TIMEOUT_EN defined, the counter SHALL clear on ack or redirect.
REQ-035 With FETCH_TIMEOUT_EN defined, when the counter reaches 15 the block SHALL set fetch_err=1 and halted=1 and go to HALTED.
REQ-036 Without FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely and fetch_err SHALL be tied to 0.

Verification
REQ-037 Reset, 1-cycle ack latency, id_ready=1, imem returns 0x1234 then 0x5678 -> if_pc 0x0000 then 0x0002; if_instr 0x1234 then 0x5678.
REQ-038 id_ready=0 for 3 cycles in HOLD -> if_valid and if_instr stable; no imem_req until acceptance.
REQ-039 redirect=1 with redirect_pc=0x0041 in the same cycle as imem_ack -> ack dropped; next imem_addr=0x0040.
REQ-040 Instruction 0xF000 with halt=1 accepted -> halted=1 in the next cycle; imem_req stays 0 for 20 cycles; rst_n pulse restarts at 0x0000.
REQ-041 redirect_pc=0xFFFE with instruction accepted -> next imem_addr=0x0000.
REQ-042 With FETCH_TIMEOUT_EN, no ack for 15 cycles -> fetch_err=1, halted=1; without the macro, ack at cycle 40 -> normal completion.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Single-outstanding instruction fetch stage. Issues 16-bit halfword reads
//   to instruction memory, presents one instruction at a time to decode and
//   holds it until decode accepts it. Supports branch redirect and a
//   permanent halt that only reset can clear.
//
//   Optional build macro: FETCH_TIMEOUT_EN
//     When defined, a 4-bit counter watches FETCH cycles without imem_ack.
//     After 15 such cycles the unit raises fetch_err and halts. When it is
//     undefined, FETCH waits forever and fetch_err is tied low.
//
// Ports
//   clk, rst_n           clock / async active-low reset
//   imem_req, imem_addr  read request and halfword-aligned byte address
//   imem_ack, imem_rdata read data strobe (1-cycle pulse) and data
//   if_valid, if_instr   instruction presented to decode
//   if_pc, if_pc_plus2   address of if_instr and that address + 2
//   id_ready             decode consumes if_instr this cycle
//   halt                 decode saw a Halt in if_instr
//   redirect, redirect_pc taken branch and its target
//   halted, fetch_err    permanent stop / memory timeout
// ---------------------------------------------------------------------------
module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  input  logic        id_ready,
  input  logic        halt,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        vld_q, vld_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifpc_q, ifpc_d;
  logic        halted_q, halted_d;
`ifdef FETCH_TIMEOUT_EN
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  // Branch targets are forced halfword aligned.
  logic [15:0] redir_tgt;
  assign redir_tgt = redirect_pc & 16'hFFFE;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    vld_d    = vld_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    halted_d = halted_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          // Redirect wins; an ack landing this cycle is for the old path.
          pc_d  = redir_tgt;
          vld_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          cnt_d = 4'd0;
`endif
        end else if (req_q && imem_ack) begin
          // req_q gates the ack: it is low in the first cycle out of reset.
          instr_d = imem_rdata;
          ifpc_d  = pc_q;
          vld_d   = 1'b1;
          pc_d    = pc_q + 16'd2;
          state_d = S_HOLD;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = 4'd0;
`endif
        end
`ifdef FETCH_TIMEOUT_EN
        else if (req_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd14) begin
            err_d    = 1'b1;
            halted_d = 1'b1;
            state_d  = S_HALTED;
          end
        end
`endif
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = redir_tgt;
          vld_d   = 1'b0;
          state_d = S_FETCH;
        end else if (id_ready) begin
          // halt only matters when the held instruction is consumed.
          vld_d = 1'b0;
          if (halt) begin
            halted_d = 1'b1;
            state_d  = S_HALTED;
          end else begin
            state_d  = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        vld_d    = 1'b0;
        halted_d = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Registered request: low through reset, high the cycle after entering
    // FETCH, low in HOLD/HALTED.
    req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= 16'h0000;
      req_q    <= 1'b0;
      vld_q    <= 1'b0;
      instr_q  <= 16'h0000;
      ifpc_q   <= 16'h0000;
      halted_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      vld_q    <= vld_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
      halted_q <= halted_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_valid    = vld_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign if_pc_plus2 = ifpc_q + 16'd2;
  assign halted      = halted_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err   = err_q;
`else
  assign fetch_err   = 1'b0;
`endif

endmodule
